// File: rtl/mtm_alu_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mtm_alu_serializer_if
//  Purpose  : Response handshake bundle between the ALU core / error
//             detector (master) and the output serializer (slave).
//  Signals  : in_valid      master->slave  response present
//             in_ready      slave->master  serializer idle, accepts response
//             in_c[31:0]    master->slave  ALU result C
//             in_flags[3:0] master->slave  {carry, overflow, zero, negative}
//             in_err_flags  master->slave  {ERR_DATA, ERR_CRC, ERR_OP}
//  Revision : 1.0  initial release
// ============================================================================
interface mtm_alu_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_c;
    logic [3:0]  in_flags;
    logic [2:0]  in_err_flags;

    modport master (
        output in_valid,
        output in_c,
        output in_flags,
        output in_err_flags,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_c,
        input  in_flags,
        input  in_err_flags,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mtm_alu_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : mtm_alu_serializer
//  Purpose  : Serializes one ALU response onto the single-wire sout line as
//             11-bit frames {start 0, type, d[7:0], stop 1}, MSB first, one
//             bit per clk. A result is four DATA frames (C, MSB byte first)
//             followed by a CTL frame {0, flags, crc3}; an error is a single
//             CTL frame {1, err, err, parity}.
//  Ports    : clk    system clock, rising edge
//             rst_n  asynchronous active-low reset
//             bus    response handshake (slave side)
//             sout   serial output, idle high, registered
//             busy   high while a response is being transmitted
//  Revision : 1.0  initial release
// ============================================================================
module mtm_alu_serializer (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mtm_alu_serializer_if.slave bus,
    output logic              sout,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CTL  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_BIT  = 4'd10;
    localparam logic [1:0] c_LAST_BYTE = 2'd3;

    state_t      r_state;
    logic [31:0] r_c;
    logic [3:0]  r_flags;
    logic [2:0]  r_err;
    logic [2:0]  r_crc;
    logic [3:0]  r_bitcnt;
    logic [1:0]  r_byte;
    logic        r_sout;

    logic        w_accept;
    logic [2:0]  w_crc_in;
    logic [7:0]  w_data_byte;
    logic [7:0]  w_err_byte;
    logic [10:0] w_frame;
    logic        w_next_bit;

    // CRC3 over {C, 0, flags, 000}, MSB first, evaluated in parallel on the
    // inputs so the checksum is ready at the accept edge.
    function automatic logic [2:0] crc3_f(input logic [31:0] c, input logic [3:0] fl);
        logic [39:0] s;
        logic [2:0]  r;
        s = {c, 1'b0, fl, 3'b000};
        r = 3'b000;
        for (int i = 39; i >= 0; i--) begin
            r = {r[1], r[2] ^ r[0], r[2] ^ s[i]};
        end
        return r;
    endfunction

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_crc_in = crc3_f(bus.in_c, bus.in_flags);

    always_comb begin
        w_data_byte = 8'h00;
        case (r_byte)
            2'd0:    w_data_byte = r_c[31:24];
            2'd1:    w_data_byte = r_c[23:16];
            2'd2:    w_data_byte = r_c[15:8];
            default: w_data_byte = r_c[7:0];
        endcase
    end

    // Trailing bit makes the byte's ones count even.
    assign w_err_byte = {1'b1, r_err, r_err, ^{1'b1, r_err, r_err}};

    // Frame currently on the line; bit 10 is the start bit.
    always_comb begin
        w_frame = 11'h7FF;
        case (r_state)
            ST_DATA: w_frame = {1'b0, 1'b0, w_data_byte, 1'b1};
            ST_CTL:  w_frame = {1'b0, 1'b1, 1'b0, r_flags, r_crc, 1'b1};
            ST_ERR:  w_frame = {1'b0, 1'b1, w_err_byte, 1'b1};
            default: w_frame = 11'h7FF;
        endcase
    end

    // r_bitcnt names the bit being driven now; the next one is frame bit
    // index (10 - (r_bitcnt + 1)). Only used while r_bitcnt < 10.
    assign w_next_bit = w_frame[4'd9 - r_bitcnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_c      <= 32'h0;
            r_flags  <= 4'h0;
            r_err    <= 3'h0;
            r_crc    <= 3'h0;
            r_bitcnt <= 4'd0;
            r_byte   <= 2'd0;
            r_sout   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sout <= 1'b1;
                    if (w_accept) begin
                        r_c      <= bus.in_c;
                        r_flags  <= bus.in_flags;
                        r_err    <= bus.in_err_flags;
                        r_crc    <= w_crc_in;
                        r_bitcnt <= 4'd0;
                        r_byte   <= 2'd0;
                        r_sout   <= 1'b0;
                        r_state  <= (bus.in_err_flags == 3'b000) ? ST_DATA : ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (r_bitcnt == c_LAST_BIT) begin
                        // Frames run back-to-back: next start bit follows the stop bit.
                        r_bitcnt <= 4'd0;
                        r_sout   <= 1'b0;
                        if (r_byte == c_LAST_BYTE) begin
                            r_byte  <= 2'd0;
                            r_state <= ST_CTL;
                        end else begin
                            r_byte <= r_byte + 2'd1;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                        r_sout   <= w_next_bit;
                    end
                end
                ST_CTL, ST_ERR: begin
                    if (r_bitcnt == c_LAST_BIT) begin
                        r_bitcnt <= 4'd0;
                        r_sout   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                        r_sout   <= w_next_bit;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sout  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign sout         = r_sout;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mtm_alu_serializer
//  Purpose  : Directed self-checking bench for mtm_alu_serializer: decodes
//             the sout line frame by frame and compares against constants
//             and a CRC3 reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mtm_alu_serializer;

    logic clk = 1'b0;
    logic rst_n;
    logic sout;
    logic busy;

    mtm_alu_serializer_if bus_if ();

    mtm_alu_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .sout  (sout),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_crc3(input logic [31:0] c, input logic [3:0] fl);
        logic [39:0] s;
        logic [2:0]  r;
        s = {c, 1'b0, fl, 3'b000};
        r = 3'b000;
        for (int i = 39; i >= 0; i--) r = {r[1], r[2] ^ r[0], r[2] ^ s[i]};
        return r;
    endfunction

    function automatic logic [10:0] mk_frame(input logic typ, input logic [7:0] d);
        return {1'b0, typ, d, 1'b1};
    endfunction

    // One bit per falling edge, first sample lands in bit 10.
    task automatic recv_frame(output logic [10:0] f);
        f = 11'h0;
        repeat (11) begin
            @(negedge clk);
            f = {f[9:0], sout};
        end
    endtask

    task automatic rx_result(input string tag, input logic [31:0] c, input logic [3:0] fl,
                             output logic [31:0] dc, output logic [3:0] dfl,
                             output logic [10:0] ctl);
        logic [10:0] f;
        logic [7:0]  b;
        dc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            recv_frame(f);
            b = c[31 - 8*i -: 8];
            check($sformatf("%s.byte%0d", tag, i), 64'(f), 64'(mk_frame(1'b0, b)));
            dc = {dc[23:0], f[8:1]};
        end
        recv_frame(f);
        check({tag, ".ctl"}, 64'(f), 64'(mk_frame(1'b1, {1'b0, fl, ref_crc3(c, fl)})));
        dfl = f[7:4];
        ctl = f;
        check({tag, ".ready_last_bit"}, 64'(bus_if.in_ready), 64'(1'b0));
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, ".idle_ready"}, 64'(bus_if.in_ready), 64'(1'b1));
        check({tag, ".idle_sout"},  64'(sout), 64'(1'b1));
    endtask

    task automatic present(input logic [31:0] c, input logic [3:0] fl, input logic [2:0] err);
        @(negedge clk);
        bus_if.in_c         = c;
        bus_if.in_flags     = fl;
        bus_if.in_err_flags = err;
        bus_if.in_valid     = 1'b1;
        @(posedge clk);
        #1 bus_if.in_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] dc;
        logic [3:0]  dfl;
        logic [10:0] ctl;
        logic [10:0] f;
        logic [2:0]  errs [3];
        logic [7:0]  ebytes [3];

        errs[0] = 3'b100; ebytes[0] = 8'hC9;
        errs[1] = 3'b010; ebytes[1] = 8'hA5;
        errs[2] = 3'b001; ebytes[2] = 8'h93;

        rst_n               = 1'b0;
        bus_if.in_valid     = 1'b0;
        bus_if.in_c         = 32'h0;
        bus_if.in_flags     = 4'h0;
        bus_if.in_err_flags = 3'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.sout",  64'(sout), 64'(1'b1));
        check("reset.ready", 64'(bus_if.in_ready), 64'(1'b1));
        check("reset.busy",  64'(busy), 64'(1'b0));
        @(negedge clk) rst_n = 1'b1;

        // All-zero result: CTL frame with crc3 = 000
        present(32'h0000_0000, 4'b0000, 3'b000);
        #1 check("zero.busy", 64'(busy), 64'(1'b1));
        rx_result("zero", 32'h0, 4'b0000, dc, dfl, ctl);
        check("zero.ctl_const", 64'(ctl), 64'(11'b0_1_00000000_1));
        check_idle("zero");

        // flags = 0001: CTL byte 0x0B
        present(32'h0000_0000, 4'b0001, 3'b000);
        rx_result("fl1", 32'h0, 4'b0001, dc, dfl, ctl);
        check("fl1.ctl_byte", 64'(ctl[8:1]), 64'(8'h0B));
        check_idle("fl1");

        // DEADBEEF, flags 1000: monitor-decoded values
        present(32'hDEAD_BEEF, 4'b1000, 3'b000);
        rx_result("dead", 32'hDEAD_BEEF, 4'b1000, dc, dfl, ctl);
        check("dead.decoded_c",     64'(dc),  64'(32'hDEAD_BEEF));
        check("dead.decoded_flags", 64'(dfl), 64'(4'b1000));
        check_idle("dead");

        // Error responses: single CTL frame, C and flags ignored
        for (int i = 0; i < 3; i++) begin
            present(32'hFFFF_FFFF, 4'hF, errs[i]);
            recv_frame(f);
            check($sformatf("err%0d.frame", i), 64'(f), 64'(mk_frame(1'b1, ebytes[i])));
            check($sformatf("err%0d.ready_last_bit", i), 64'(bus_if.in_ready), 64'(1'b0));
            check_idle($sformatf("err%0d", i));
        end

        // Back-to-back with in_valid held high; inputs change after accept
        @(negedge clk);
        bus_if.in_c         = 32'h1234_5678;
        bus_if.in_flags     = 4'b0101;
        bus_if.in_err_flags = 3'b000;
        bus_if.in_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_c         = 32'hA5A5_0F0F;
        bus_if.in_flags     = 4'b0010;
        rx_result("b2bA", 32'h1234_5678, 4'b0101, dc, dfl, ctl);
        @(negedge clk);
        check("b2b.gap_sout",  64'(sout), 64'(1'b1));
        check("b2b.gap_ready", 64'(bus_if.in_ready), 64'(1'b1));
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
        rx_result("b2bB", 32'hA5A5_0F0F, 4'b0010, dc, dfl, ctl);
        check_idle("b2bB");

        // Reset during bit 5 of byte 2
        present(32'h1122_3344, 4'b0110, 3'b000);
        recv_frame(f);
        recv_frame(f);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.sout",  64'(sout), 64'(1'b1));
        check("midrst.ready", 64'(bus_if.in_ready), 64'(1'b1));
        check("midrst.busy",  64'(busy), 64'(1'b0));
        @(negedge clk) rst_n = 1'b1;
        present(32'h0000_0000, 4'b0001, 3'b000);
        rx_result("postrst", 32'h0, 4'b0001, dc, dfl, ctl);
        check("postrst.ctl_const", 64'(ctl), 64'(11'b0_1_00001011_1));
        check_idle("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mtm_alu_serializer.md
# mtm_alu_serializer

Output-side serializer of the mtm_Alu datapath. It accepts one ALU response (32-bit result C plus 4 flags, or a 3-bit error code) over a valid/ready handshake and transmits it on the single-wire `sout` line. The line format is the one the testbench result monitor decodes: 11-bit frames, one bit per `clk`, MSB first. It sits between the ALU core/error detector and the `sout` pin.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  response present on `in_*`.
- `in_ready`  out  1  block idle; response accepted on posedge when `in_valid && in_ready`.
- `in_c`  in  32  ALU result C.
- `in_flags`  in  4  result flags {carry, overflow, zero, negative}, sent as given.
- `in_err_flags`  in  3  error code {ERR_DATA, ERR_CRC, ERR_OP}; nonzero selects an error response.
- `sout`  out  1  serial output, idle high, registered.
- `busy`  out  1  high while a response is being transmitted (`!in_ready`).

## Operation
- Frame (11 bits, MSB first): start 0, type bit (0 = DATA, 1 = CTL), d[7:0], stop 1.
- Result response (`in_err_flags == 0`): 5 frames, sent back-to-back with no idle bits between them.
  - Frames 1-4: DATA frames with C[31:24], C[23:16], C[15:8], C[7:0].
  - Frame 5: CTL frame with d = {1'b0, flags[3:0], crc3[2:0]}.
- Error response (`in_err_flags != 0`): one CTL frame with d = {1'b1, err[2:0], err[2:0], p}.
  - p = XOR of d[7:1], so the total number of ones in the byte is even.
  - C and flags are ignored.
- CRC3 definition:
  - Computed over the 40-bit stream {C[31:0], 1'b0, flags[3:0], 3'b000}, MSB first.
  - r starts at 3'b000.
  - Per bit: r = {r[1], r[2]^r[0], r[2]^din}.
  - crc3 = final r.
  - Serial computation alongside transmission or a parallel equivalent is allowed; the result must be bit-exact.
- All `in_*` values are captured into internal registers at the accept edge. Input changes during transmission have no effect.
- FSM:
  - IDLE: `in_ready = 1`, `sout = 1`. On accept go to DATA if `in_err_flags == 0`, else to ERR.
  - DATA: byte index 0..3, bit counter 0..10. After bit 10 of byte 3, go to CTL.
  - CTL: 11 bits. After the stop bit, go to IDLE.
  - ERR: 11 bits. After the stop bit, go to IDLE.
- Counters: the bit counter wraps 10 -> 0 at each frame boundary. The byte index increments only on that wrap.

## Timing
- Reset (asynchronous, any state): `sout = 1`, state IDLE, `in_ready = 1`, `busy = 0`, counters and CRC cleared. Any frame in progress is abandoned immediately; there is no partial stop bit.
- Reset release: the first accept is possible on the first posedge with `rst_n` high.
- Accept edge T: `sout` carries the start bit (0) during cycle T+1.
- Each bit is held exactly one `clk` period.
- Result response: `sout` bits occupy cycles T+1 .. T+55. `in_ready` rises at the edge ending cycle T+55.
- Error response: bits occupy cycles T+1 .. T+11. `in_ready` rises at the edge ending cycle T+11.
- Back-to-back responses: `in_valid` held high with new data is accepted on the first edge `in_ready` is high, so at least one idle (`sout = 1`) cycle follows every final stop bit.
- `in_valid` while busy: ignored and not buffered. The producer holds its data until `in_ready`.
- `in_ready` is combinational from state only and never depends on `in_valid`.

## Test plan
- C = 32'h0000_0000, flags = 4'b0000, err = 0:
  - 4 frames 0,0,00000000,1.
  - Then a CTL frame 0,1,00000000,1 (crc3 = 000).
  - 55 bits total, then `in_ready` = 1.
- C = 32'h0000_0000, flags = 4'b0001: CTL byte = 8'h0B (crc3 = 3'b011).
- C = 32'hDEAD_BEEF, flags = 4'b1000:
  - Data bytes DE, AD, BE, EF in order.
  - CTL crc3 equals the bench reference model.
  - The monitor's decoded C and flags match the inputs.
- err = 3'b100, 3'b010, 3'b001:
  - Single CTL frames with bytes 8'hC9, 8'hA5, 8'h93 respectively.
  - 11 bits each; C is ignored.
- Back-to-back: two results with `in_valid` held high.
  - Exactly one idle cycle between the final stop bit and the next start bit.
  - Inputs changed mid-transmission do not alter the first response.
- `rst_n` pulled low at bit 5 of byte 2:
  - `sout` = 1 and `in_ready` = 1 immediately.
  - After release, a new response transmits correctly from its start bit.
